// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_enc_pkg
// Description : Shared definitions for the RISC-V instruction encoder:
//               format codes, NOP word, common opcodes, output payload type
//               and the immediate sign-extension range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_enc_pkg;

  // Instruction format selector carried on in_fmt (6 and 7 are illegal)
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // addi x0, x0, 0 -- emitted in place of an illegal format
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Base opcodes used by the boot/debug injector
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // Masks covering the immediate bits that must be a pure sign extension
  localparam logic [63:0] MASK_SEXT_IB = ~64'd0 << 11;  // I/B: imm[63:11]
  localparam logic [63:0] MASK_ZERO_S  = ~64'd0 << 12;  // S:   imm[63:12]
  localparam logic [63:0] MASK_SEXT_U  = ~64'd0 << 31;  // U:   imm[63:31]
  localparam logic [63:0] MASK_SEXT_J  = ~64'd0 << 19;  // J:   imm[63:19]

  // Encoded word plus its error flag, as held in the output stage
  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_payload_t;

  localparam int PAYLOAD_W = $bits(enc_payload_t);

  // True when every immediate bit selected by mask holds the same value
  function automatic logic sext_fits(input logic [63:0] imm,
                                     input logic [63:0] mask);
    logic [63:0] sel;
    sel = imm & mask;
    return (sel == 64'd0) || (sel == mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_enc_skid.sv
`default_nettype none
// ============================================================================
// Module      : inst_enc_skid
// Description : Output register plus one skid entry. ready_o is a pure
//               register decode (skid empty), so there is no combinational
//               path from pop_i to ready_o.
// Ports       : clk, rstn      - clock / async active-low reset
//               push_i, data_i - write one payload (only while ready_o)
//               ready_o        - skid entry free
//               valid_o,data_o - output register contents
//               pop_i          - consumer takes the output register
// Revision    : 1.0 - initial release
// ============================================================================
module inst_enc_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);

  logic         out_v_q,  out_v_d;
  logic [W-1:0] out_dt_q, out_dt_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] skid_dt_q, skid_dt_d;

  // The skid entry is only ever occupied while the output register is, so
  // an empty output register implies an empty skid.
  always_comb begin
    out_v_d   = out_v_q;
    out_dt_d  = out_dt_q;
    skid_v_d  = skid_v_q;
    skid_dt_d = skid_dt_q;
    if (out_v_q && pop_i) begin
      if (skid_v_q) begin
        // Older skid word moves forward; push cannot happen (ready_o=0)
        out_dt_d = skid_dt_q;
        skid_v_d = 1'b0;
      end else if (push_i) begin
        out_dt_d = data_i;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (out_v_q) begin
      if (push_i) begin
        skid_v_d  = 1'b1;
        skid_dt_d = data_i;
      end
    end else if (push_i) begin
      out_v_d  = 1'b1;
      out_dt_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_v_q   <= 1'b0;
      out_dt_q  <= '0;
      skid_v_q  <= 1'b0;
      skid_dt_q <= '0;
    end else begin
      out_v_q   <= out_v_d;
      out_dt_q  <= out_dt_d;
      skid_v_q  <= skid_v_d;
      skid_dt_q <= skid_dt_d;
    end
  end

  assign ready_o = ~skid_v_q;
  assign valid_o = out_v_q;
  assign data_o  = out_dt_q;

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Streaming RISC-V instruction encoder. Packs field-level
//               requests into 32-bit words, range-checks the immediate and
//               presents the result through a registered output with skid.
// Ports       : clk, rstn                 - clock / async active-low reset
//               in_valid/in_ready         - request handshake
//               in_fmt..in_imm            - instruction fields
//               out_valid/out_ready       - result handshake
//               out_inst, out_err         - encoded word and error flag
//               enc_count, err_count      - accepted / erroneous counters
// Config      : INST_ENC_ERR_DROP_EN - erroneous requests are accepted and
//               counted but never output; out_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      w_inst;
  logic             w_err;
  logic             w_accept;
  logic             w_push;
  enc_payload_t     w_pay_in;
  enc_payload_t     w_pay_out;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Packing and range check. Out-of-range immediates still pack their
  // truncated low bits so the consumer sees what would have been encoded.
  always_comb begin
    w_inst = NOP_INST;
    w_err  = 1'b0;
    case (in_fmt)
      FMT_R: begin
        w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = ~sext_fits(in_imm, MASK_SEXT_IB);
      end
      FMT_S: begin
        // Store offsets are zero-extended downstream: valid range 0..4095
        w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err  = |(in_imm & MASK_ZERO_S);
      end
      FMT_B: begin
        // in_imm already holds the byte offset shifted right by one
        w_inst = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                  in_imm[3:0], in_imm[10], in_opcode};
        w_err  = ~sext_fits(in_imm, MASK_SEXT_IB);
      end
      FMT_U: begin
        w_inst = {in_imm[31:12], in_rd, in_opcode};
        w_err  = ~sext_fits(in_imm, MASK_SEXT_U) | (|in_imm[11:0]);
      end
      FMT_J: begin
        // in_imm already holds the byte offset shifted right by one
        w_inst = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11],
                  in_rd, in_opcode};
        w_err  = ~sext_fits(in_imm, MASK_SEXT_J);
      end
      default: begin
        w_inst = NOP_INST;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;

`ifdef INST_ENC_ERR_DROP_EN
  assign w_push = w_accept & ~w_err;
`else
  assign w_push = w_accept;
`endif

  assign w_pay_in.err  = w_err;
  assign w_pay_in.inst = w_inst;

  inst_enc_skid #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (w_push),
    .data_i  (w_pay_in),
    .ready_o (in_ready),
    .valid_o (out_valid),
    .data_o  (w_pay_out),
    .pop_i   (out_ready)
  );

  assign out_inst = w_pay_out.inst;
`ifdef INST_ENC_ERR_DROP_EN
  assign out_err = 1'b0;
`else
  assign out_err = w_pay_out.err;
`endif

  // enc_count wraps; err_count sticks at all-ones
  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (w_accept) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if (w_err && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed self-checking bench for inst_encoder. Expected
//               words are hand-encoded constants.
// Config      : INST_ENC_ERR_DROP_EN - expectations for the drop build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] imm);
    in_fmt = f; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One request with out_ready held high; result checked one cycle later
  task automatic dir(input string tag, input logic [2:0] f, input logic [6:0] opc,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm,
                     input logic [31:0] e_inst, input logic e_err);
    set_req(f, opc, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef INST_ENC_ERR_DROP_EN
    if (e_err) begin
      check({tag, "_dropped"}, out_valid, 64'd0);
    end else begin
      check({tag, "_valid"}, out_valid, 64'd1);
      check({tag, "_inst"}, out_inst, e_inst);
      check({tag, "_err"}, out_err, 64'd0);
    end
`else
    check({tag, "_valid"}, out_valid, 64'd1);
    check({tag, "_inst"}, out_inst, e_inst);
    check({tag, "_err"}, out_err, e_err);
`endif
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, low;
    logic [32:0] exp_q[$];
    logic [31:0] e;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_inst", out_inst, 64'd0);
    check("rst_out_err", out_err, 64'd0);
    check("rst_enc_count", enc_count, 64'd0);
    check("rst_err_count", err_count, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 64'd1);

    // ---------------- directed encodings ----------------
    dir("addi",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5,                  32'h00500093, 1'b0);
    dir("beq_m4",  3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE208EE3, 1'b0);
    dir("i_2048",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd2048,               32'h80000093, 1'b1);
    check("i_2048_errcnt", err_count, 64'd1);
    dir("i_m2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F800, 32'h80000093, 1'b0);
    dir("s_4095",  3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 64'd4095,               32'hFE312FA3, 1'b0);
    dir("s_4096",  3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 64'd4096,               32'h00312023, 1'b1);
    dir("u_1001",  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'h1001,               32'h000012B7, 1'b1);
    dir("u_neg",   3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 32'h800002B7, 1'b0);
    dir("jal_8",   3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd4,                  32'h008000EF, 1'b0);
    dir("jal_big", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h8_0000,             32'h800000EF, 1'b1);
    dir("jal_m2",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFF0EF, 1'b0);
    dir("sub",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'hDEAD_BEEF_0000_0000, 32'h402081B3, 1'b0);
    dir("fmt6",    3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0,                  32'h00000013, 1'b1);
    dir("b_2048",  3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd2048,               32'h80208063, 1'b1);
    @(posedge clk); #1;
    check("dir_enc_count", enc_count, 64'd14);
    check("dir_err_count", err_count, 64'd6);
    check("dir_idle_valid", out_valid, 64'd0);

    // ---------------- reset with both entries full ----------------
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 64'd7);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 64'd0);
    check("full_out_valid", out_valid, 64'd1);
    rstn = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 64'd0);
    check("arst_out_inst", out_inst, 64'd0);
    check("arst_enc_count", enc_count, 64'd0);
    check("arst_in_ready", in_ready, 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_stale", out_valid, 64'd0);
    end

    // ---------------- backpressure stream ----------------
    sent = 0; got = 0; low = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid  = (sent < 8);
      set_req(3'd1, 7'h13, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'h00, 64'(sent + 1));
      out_ready = !(c >= 3 && c <= 6);
      if (!in_ready) low++;
      if (out_valid && out_ready) begin
        e = ((32'(got) + 32'd1) << 20) | ((32'(got) + 32'd1) << 7) | 32'h13;
        check($sformatf("bp_out%0d", got), out_inst, e);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_outputs", got, 64'd8);
    check("bp_in_ready_low", low, 64'd4);
    check("bp_enc_count", enc_count, 64'd8);
    check("bp_drained", out_valid, 64'd0);

    // ---------------- good / bad / good ----------------
    do_reset();
    exp_q.push_back({1'b0, 32'h00900493});      // addi x9, x0, 9
`ifndef INST_ENC_ERR_DROP_EN
    exp_q.push_back({1'b1, 32'h80000093});      // addi x1, x0, 2048 (truncated)
`endif
    exp_q.push_back({1'b0, 32'h00A00513});      // addi x10, x0, 10
    got = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 3);
      case (c)
        0:       set_req(3'd1, 7'h13, 5'd9,  5'd0, 5'd0, 3'd0, 7'h00, 64'd9);
        1:       set_req(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'd2048);
        default: set_req(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 64'd10);
      endcase
      if (out_valid) begin
        if (got < exp_q.size()) begin
          check($sformatf("gbg_out%0d", got), {out_err, out_inst}, exp_q[got]);
        end else begin
          check("gbg_extra_output", {out_err, out_inst}, 64'h1_FFFF_FFFF);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("gbg_outputs", got, exp_q.size());
    check("gbg_enc_count", enc_count, 64'd3);
    check("gbg_err_count", err_count, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V instruction encoder: the inverse of the datapath's immediate decode.
- Accepts field-level descriptions (format, opcode, registers, functs, 64-bit immediate) and emits packed 32-bit instructions.
- Feeds the boot/debug instruction injector in front of instruction memory.
- Valid/ready on both sides; registered output with a skid buffer; immediate range checking; statistics counters.

Parameters:
- CNT_W, 16, width of the accepted-instruction and error counters

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept; registered, no combinational path from out_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal
- in_opcode  in  7  placed in inst[6:0] unchanged
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  inst[14:12]
- in_funct7  in  7  inst[31:25], R only
- in_imm  in  64  immediate, same convention as the datapath decoder output
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate out of range, or illegal fmt
- enc_count  out  CNT_W  accepted requests, wraps
- err_count  out  CNT_W  erroneous requests, saturates at all-ones

Behaviour:
Reset values:
- out_valid=0, out_inst=0, out_err=0, counters=0.
- in_ready=1 from the first clock after rstn deasserts.
- Reset mid-transfer discards all held entries; no partial output.

Handshake:
- Transfer occurs on an edge where valid&ready.
- Latency 1: request accepted at edge N gives out_valid at N+1.
- Full throughput while out_ready=1.
- out_valid/out_inst/out_err hold stable until accepted.
- Skid entry absorbs one extra request when out_ready falls. in_ready=0 exactly when the skid entry is occupied.
- On out_ready=1, skid drains into the output register the same edge.
- Simultaneous accept and drain on the same edge is legal. The order is preserved.

Field packing (rd→[11:7], rs1→[19:15], rs2→[24:20], funct3→[14:12] where the format has them):
- R: [31:25]=funct7.
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: imm is byte offset>>1. [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
- U: [31:12]=imm[31:12].
- J: imm is byte offset>>1. [31]=imm[19], [19:12]=imm[18:11], [20]=imm[10], [30:21]=imm[9:0].

Range rules (out_err=1 when violated):
- I, B: imm[63:11] all equal (signed 12-bit).
- S: imm[63:12]==0. Store offsets are zero-extended by the datapath, so the range is 0..4095.
- U: imm[63:31] all equal and imm[11:0]==0.
- J: imm[63:19] all equal.
- R: imm ignored, never errors.
- fmt 6/7: out_err=1, out_inst=32'h00000013 (NOP).
- A range violation still packs the truncated field bits.

Counters:
- enc_count increments on every input transfer.
- err_count increments on every input transfer flagged erroneous; holds at all-ones.

Optional Feature:
- INST_ENC_ERR_DROP_EN defined: erroneous requests are accepted and counted but never presented at the output. out_err is tied to 0.
- Undefined: erroneous requests are output with out_err=1 as above.

Decomposition:
- Shared package inst_enc_pkg holds:
  - fmt encodings FMT_R..FMT_J
  - NOP constant 32'h00000013
  - opcode constants (OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE)
- One sub-module: inst_enc_skid, a 2-entry output register plus skid, parameterised on payload width 33 (inst+err).
- Packing and range check are combinational in the top.

Test Plan:
- I-type: fmt=1, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_inst=32'h00500093, out_err=0, one cycle later.
- B-type: fmt=3, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=64'hFFFF_FFFF_FFFF_FFFE (offset −4) -> out_inst=32'hFE208EE3, out_err=0.
- Range checks:
  - I imm=2048 -> out_err=1, err_count=1.
  - S imm=4095 -> out_err=0.
  - U imm=32'h0000_1001 -> out_err=1.
- Backpressure: stream 8 requests, out_ready low for cycles 3–6 -> in_ready drops after one skid fill; all 8 emerge in order with no duplicates; enc_count=8.
- Reset with both entries full -> out_valid=0 the same cycle as rstn=0; counters=0; no stale output after release.
- Macro INST_ENC_ERR_DROP_EN: 3 requests with the middle one erroneous -> only 2 outputs; err_count=1, enc_count=3.
